quad_core_fetch_unit: RTL and testbench
=======================================

// Module: quad_core_fetch_unit
// PURPOSE
//  Per-core instruction fetch stage for the 4-core parallel processor. Holds one PC per core and drives
//  the four read addresses of the shared 16-bit instruction RAM.
//  Captures each returned word into a one-entry instruction register per core and presents it downstream
//  with a valid/ready handshake.
//  Detects the halt word 16'hFFFF and freezes that core.
// PARAMETERS
//  CORE0_BASE  16'd0   start PC of core 0
//  CORE1_BASE  16'd6   start PC of core 1
//  CORE2_BASE  16'd12  start PC of core 2
//  CORE3_BASE  16'd18  start PC of core 3
//  HALT_WORD   16'hFFFF  instruction word that halts a core
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  start          in   1   one-cycle pulse; moves every IDLE core to RUN
//  ram_address0-3 out  16  read address per core to the instruction RAM, = pc[i], combinational
//  ram_dataout0-3 in   16  combinational read data per core from the RAM, same cycle
//  instr          out  64  instr[16*i+15:16*i] = instruction register of core i
//  instr_valid    out  4   bit i: instr slice i holds an unconsumed word
//  instr_ready    in   4   bit i: decode of core i accepts the word this cycle
//  redirect_en    in   4   bit i: load pc[i] from redirect_addr slice i (branch/jump)
//  redirect_addr  in   64  target PCs, packed like instr
//  halted         out  4   bit i: core i is in HALT
//  all_halted     out  1   &halted
// BEHAVIOUR
//  Reset: pc[i]=CORE<i>_BASE, state=IDLE, instr=0, instr_valid=0, halted=0, all_halted=0.
//   Reset dominates every other input in the same cycle, including mid-fetch.
//  Per-core FSM, 3 states, all four independent:
//   IDLE: instr_valid=0, pc held. start=1 -> RUN. redirect in IDLE updates pc, stays IDLE.
//   RUN: see load rule below.
//   HALT: halted[i]=1, pc frozen, all inputs ignored; left only by reset.
//  Load rule in RUN, priority: redirect > load.
//   redirect_en[i]=1: pc<=redirect_addr[i], instr_valid<=0 (flush, even if held),
//    no capture this cycle. A fresh word is presented 1 cycle later.
//   Else, if slot free (instr_valid=0 or instr_ready=1), with word = ram_dataout[i]:
//    - word!=HALT_WORD: instr<=word, instr_valid<=1, pc<=pc+1.
//    - word==HALT_WORD: instr_valid<=0, pc unchanged, state<=HALT.
//   Else (valid && !ready): instr, instr_valid and pc all held (stall).
//  Latency: word at pc appears on instr the cycle after address is driven. Sustained throughput
//   1 word/cycle/core when ready held high.
//  pc arithmetic: 16-bit modulo; 16'hFFFF+1 -> 16'h0000, no flag.
//  A word consumed (valid&&ready) in the cycle HALT is detected is still consumed normally.
//  All four ports may address the same word simultaneously; no arbitration (RAM is 4-port).
//  A HALT_WORD fetched while stalled is not examined until the slot frees.
// TESTING
//  1 reset, start, ready=4'hF, RAM image [0..23] = 0000,0001,0002,2002,2004,800A,0003,...
//    -> core0 presents 0000,0001,0002 on consecutive cycles from cycle start+1;
//       core2 presents 0005,0006,2004.
//  2 core1 ready=0 for 3 cycles after first valid
//    -> instr slice1 holds 0003, pc1 holds 7; resumes with 0004 next.
//  3 redirect_en[0]=1, redirect_addr=16'd12 while valid=1
//    -> valid drops 1 cycle, then 0005; pc0=13.
//  4 memory[24]=FFFF, core3 runs 18..24
//    -> 0007,0008,0009,800D,2010,2010 presented, then halted[3]=1, valid[3]=0, pc3=24;
//       later redirect ignored.
//  5 redirect core0 to 16'hFFFF with memory[FFFF]=0001
//    -> presents 0001, pc wraps to 0000.
//  6 reset asserted mid-run with all cores valid
//    -> next cycle all outputs at reset values, pcs = bases;
//       all_halted=1 only after all four fetch FFFF.

Source files
------------

// File: rtl/quad_core_fetch_unit.sv
// Instruction fetch stage for a 4-core processor: one PC, one-entry instruction
// register and IDLE/RUN/HALT controller per core, all driving a shared 4-port RAM.

module quad_core_fetch_unit_core #(
  parameter logic [15:0] BASE      = 16'd0,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ram_data,
  input  logic        ready,
  input  logic        redirect_en,
  input  logic [15:0] redirect_addr,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  // The slot can accept a new word when it is empty or its current word is
  // being consumed this cycle.
  logic slot_free;
  logic is_halt_word;

  always_comb begin
    slot_free    = !valid || ready;
    is_halt_word = (ram_data == HALT_WORD);
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and wins over start, redirect and
    // any in-flight capture in the same cycle.
    if (reset) begin
      state  <= IDLE;
      pc     <= BASE;
      instr  <= 16'h0000;
      valid  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_en) pc <= redirect_addr;
          if (start) state <= RUN;
        end
        RUN: begin
          if (redirect_en) begin
            // Flush: any held word belongs to the abandoned path.
            pc    <= redirect_addr;
            valid <= 1'b0;
          end else if (slot_free) begin
            if (!is_halt_word) begin
              instr <= ram_data;
              valid <= 1'b1;
              pc    <= pc + 16'd1;
            end else begin
              valid  <= 1'b0;
              halted <= 1'b1;
              state  <= HALT;
            end
          end
        end
        HALT: begin
          // Frozen until reset; every input is ignored.
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

module quad_core_fetch_unit #(
  parameter logic [15:0] CORE0_BASE = 16'd0,
  parameter logic [15:0] CORE1_BASE = 16'd6,
  parameter logic [15:0] CORE2_BASE = 16'd12,
  parameter logic [15:0] CORE3_BASE = 16'd18,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] ram_address0,
  output logic [15:0] ram_address1,
  output logic [15:0] ram_address2,
  output logic [15:0] ram_address3,
  input  logic [15:0] ram_dataout0,
  input  logic [15:0] ram_dataout1,
  input  logic [15:0] ram_dataout2,
  input  logic [15:0] ram_dataout3,
  output logic [63:0] instr,
  output logic [3:0]  instr_valid,
  input  logic [3:0]  instr_ready,
  input  logic [3:0]  redirect_en,
  input  logic [63:0] redirect_addr,
  output logic [3:0]  halted,
  output logic        all_halted
);

  logic [15:0] pc       [4];
  logic [15:0] ram_data [4];

  always_comb begin
    ram_data[0] = ram_dataout0;
    ram_data[1] = ram_dataout1;
    ram_data[2] = ram_dataout2;
    ram_data[3] = ram_dataout3;
  end

  // The RAM is addressed directly by each core's PC; no arbitration needed.
  assign ram_address0 = pc[0];
  assign ram_address1 = pc[1];
  assign ram_address2 = pc[2];
  assign ram_address3 = pc[3];

  for (genvar i = 0; i < 4; i++) begin : g_core
    localparam logic [15:0] BASE = (i == 0) ? CORE0_BASE :
                                   (i == 1) ? CORE1_BASE :
                                   (i == 2) ? CORE2_BASE : CORE3_BASE;

    quad_core_fetch_unit_core #(
      .BASE      (BASE),
      .HALT_WORD (HALT_WORD)
    ) u_core (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .ram_data      (ram_data[i]),
      .ready         (instr_ready[i]),
      .redirect_en   (redirect_en[i]),
      .redirect_addr (redirect_addr[16*i +: 16]),
      .pc            (pc[i]),
      .instr         (instr[16*i +: 16]),
      .valid         (instr_valid[i]),
      .halted        (halted[i])
    );
  end

  assign all_halted = &halted;

endmodule

// File: tb/tb_quad_core_fetch_unit.sv
// Directed bench for quad_core_fetch_unit: a 64K-word RAM image in the bench
// and per-scenario tasks with hand-computed expected words and PCs.

module tb_quad_core_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ram_address0, ram_address1, ram_address2, ram_address3;
  logic [15:0] ram_dataout0, ram_dataout1, ram_dataout2, ram_dataout3;
  logic [63:0] instr;
  logic [3:0]  instr_valid;
  logic [3:0]  instr_ready;
  logic [3:0]  redirect_en;
  logic [63:0] redirect_addr;
  logic [3:0]  halted;
  logic        all_halted;

  logic [15:0] mem [0:65535];

  int compared   = 0;
  int mismatched = 0;

  quad_core_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ram_address0  (ram_address0),
    .ram_address1  (ram_address1),
    .ram_address2  (ram_address2),
    .ram_address3  (ram_address3),
    .ram_dataout0  (ram_dataout0),
    .ram_dataout1  (ram_dataout1),
    .ram_dataout2  (ram_dataout2),
    .ram_dataout3  (ram_dataout3),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .all_halted    (all_halted)
  );

  assign ram_dataout0 = mem[ram_address0];
  assign ram_dataout1 = mem[ram_address1];
  assign ram_dataout2 = mem[ram_address2];
  assign ram_dataout3 = mem[ram_address3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] slot(input int i);
    return instr[16*i +: 16];
  endfunction

  function automatic logic [15:0] addr_of(input int i);
    case (i)
      0:       return ram_address0;
      1:       return ram_address1;
      2:       return ram_address2;
      default: return ram_address3;
    endcase
  endfunction

  // Advance one clock; outputs are then sampled and inputs changed 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; redirect_en = 4'h0; redirect_addr = 64'h0; instr_ready = 4'hF;
    tick; tick;
    reset = 1'b0;
  endtask

  // Leaves the bench just after the edge that moved all cores to RUN.
  task automatic start_cores;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic init_mem;
    logic [15:0] image [25] = '{
      16'h0000, 16'h0001, 16'h0002, 16'h2002, 16'h2004, 16'h800A,
      16'h0003, 16'h0004, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
      16'h0005, 16'h0006, 16'h2004, 16'h2005, 16'h2006, 16'h2007,
      16'h0007, 16'h0008, 16'h0009, 16'h800D, 16'h2010, 16'h2010,
      16'hFFFF};
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    for (int a = 0; a < 25; a++) mem[a] = image[a];
    mem[16'hFFFF] = 16'h0001;
  endtask

  task automatic test_reset;
    logic [15:0] bases [4] = '{16'd0, 16'd6, 16'd12, 16'd18};
    reset = 1'b1; start = 1'b1; redirect_en = 4'hF; redirect_addr = {4{16'h1234}}; instr_ready = 4'hF;
    tick;
    compared++; if (instr !== 64'h0) begin mismatched++; $display("FAIL reset_instr got %h exp 0", instr); end
    compared++; if (instr_valid !== 4'h0) begin mismatched++; $display("FAIL reset_valid got %h exp 0", instr_valid); end
    compared++; if (halted !== 4'h0 || all_halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted got %h/%b exp 0/0", halted, all_halted); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (addr_of(i) !== bases[i]) begin mismatched++; $display("FAIL reset_pc%0d got %h exp %h", i, addr_of(i), bases[i]); end
    end
    reset = 1'b0; start = 1'b0; redirect_en = 4'h0;
    tick;
    compared++; if (instr_valid !== 4'h0) begin mismatched++; $display("FAIL idle_valid got %h exp 0", instr_valid); end
  endtask

  task automatic test_start_stream;
    logic [15:0] e0 [3] = '{16'h0000, 16'h0001, 16'h0002};
    logic [15:0] e1 [3] = '{16'h0003, 16'h0004, 16'h000B};
    logic [15:0] e2 [3] = '{16'h0005, 16'h0006, 16'h2004};
    logic [15:0] e3 [3] = '{16'h0007, 16'h0008, 16'h0009};
    do_reset;
    start_cores;
    compared++; if (instr_valid !== 4'h0) begin mismatched++; $display("FAIL stream_first_run_valid got %h exp 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick;
      compared++; if (instr_valid !== 4'hF) begin mismatched++; $display("FAIL stream_valid%0d got %h exp f", k, instr_valid); end
      compared++;
      if (instr !== {e3[k], e2[k], e1[k], e0[k]}) begin
        mismatched++; $display("FAIL stream_word%0d got %h exp %h", k, instr, {e3[k], e2[k], e1[k], e0[k]});
      end
    end
    compared++; if (ram_address0 !== 16'd3) begin mismatched++; $display("FAIL stream_pc0 got %h exp 3", ram_address0); end
  endtask

  task automatic test_stall;
    do_reset;
    start_cores;
    tick;
    compared++; if (slot(1) !== 16'h0003) begin mismatched++; $display("FAIL stall_first got %h exp 0003", slot(1)); end
    instr_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      tick;
      compared++;
      if (slot(1) !== 16'h0003 || instr_valid[1] !== 1'b1 || ram_address1 !== 16'd7) begin
        mismatched++; $display("FAIL stall_hold%0d got %h/%b/%h exp 0003/1/0007", k, slot(1), instr_valid[1], ram_address1);
      end
    end
    instr_ready = 4'hF;
    tick;
    compared++;
    if (slot(1) !== 16'h0004 || ram_address1 !== 16'd8) begin
      mismatched++; $display("FAIL stall_resume got %h/%h exp 0004/0008", slot(1), ram_address1);
    end
  endtask

  task automatic test_redirect;
    do_reset;
    start_cores;
    tick;
    redirect_en = 4'b0001; redirect_addr = 64'h0000_0000_0000_000C;
    tick;
    redirect_en = 4'h0;
    compared++;
    if (instr_valid[0] !== 1'b0 || ram_address0 !== 16'd12) begin
      mismatched++; $display("FAIL redirect_flush got %b/%h exp 0/000c", instr_valid[0], ram_address0);
    end
    compared++; if (instr_valid[1] !== 1'b1) begin mismatched++; $display("FAIL redirect_other_core got %b exp 1", instr_valid[1]); end
    tick;
    compared++;
    if (slot(0) !== 16'h0005 || instr_valid[0] !== 1'b1 || ram_address0 !== 16'd13) begin
      mismatched++; $display("FAIL redirect_target got %h/%b/%h exp 0005/1/000d", slot(0), instr_valid[0], ram_address0);
    end
  endtask

  task automatic test_idle_redirect;
    do_reset;
    redirect_en = 4'b0010; redirect_addr = 64'h0000_0000_0003_0000;
    tick;
    redirect_en = 4'h0;
    compared++;
    if (ram_address1 !== 16'd3 || instr_valid !== 4'h0) begin
      mismatched++; $display("FAIL idle_redirect got %h/%h exp 0003/0", ram_address1, instr_valid);
    end
    start_cores;
    tick;
    compared++; if (slot(1) !== 16'h2002) begin mismatched++; $display("FAIL idle_redirect_word got %h exp 2002", slot(1)); end
  endtask

  task automatic test_halt;
    logic [15:0] e3 [6] = '{16'h0007, 16'h0008, 16'h0009, 16'h800D, 16'h2010, 16'h2010};
    do_reset;
    start_cores;
    for (int k = 0; k < 6; k++) begin
      tick;
      compared++;
      if (slot(3) !== e3[k] || instr_valid[3] !== 1'b1) begin
        mismatched++; $display("FAIL halt_seq%0d got %h/%b exp %h/1", k, slot(3), instr_valid[3], e3[k]);
      end
    end
    tick;
    compared++;
    if (halted !== 4'b1000 || instr_valid[3] !== 1'b0 || ram_address3 !== 16'd24 || all_halted !== 1'b0) begin
      mismatched++; $display("FAIL halt_enter got %h/%b/%h/%b exp 8/0/0018/0", halted, instr_valid[3], ram_address3, all_halted);
    end
    redirect_en = 4'b1000; redirect_addr = 64'h0;
    start = 1'b1;
    tick;
    redirect_en = 4'h0; start = 1'b0;
    compared++;
    if (halted[3] !== 1'b1 || ram_address3 !== 16'd24 || instr_valid[3] !== 1'b0) begin
      mismatched++; $display("FAIL halt_ignores_redirect got %b/%h/%b exp 1/0018/0", halted[3], ram_address3, instr_valid[3]);
    end
  endtask

  task automatic test_halt_stalled;
    do_reset;
    start_cores;
    repeat (6) tick;
    instr_ready = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      tick;
      compared++;
      if (halted[3] !== 1'b0 || instr_valid[3] !== 1'b1 || slot(3) !== 16'h2010) begin
        mismatched++; $display("FAIL halt_stalled%0d got %b/%b/%h exp 0/1/2010", k, halted[3], instr_valid[3], slot(3));
      end
    end
    instr_ready = 4'hF;
    tick;
    compared++;
    if (halted[3] !== 1'b1 || instr_valid[3] !== 1'b0) begin
      mismatched++; $display("FAIL halt_after_stall got %b/%b exp 1/0", halted[3], instr_valid[3]);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    start_cores;
    redirect_en = 4'b0001; redirect_addr = 64'h0000_0000_0000_FFFF;
    tick;
    redirect_en = 4'h0;
    compared++;
    if (ram_address0 !== 16'hFFFF || instr_valid[0] !== 1'b0) begin
      mismatched++; $display("FAIL wrap_target got %h/%b exp ffff/0", ram_address0, instr_valid[0]);
    end
    tick;
    compared++;
    if (slot(0) !== 16'h0001 || ram_address0 !== 16'h0000 || instr_valid[0] !== 1'b1) begin
      mismatched++; $display("FAIL wrap_pc got %h/%h/%b exp 0001/0000/1", slot(0), ram_address0, instr_valid[0]);
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    start_cores;
    tick;
    compared++; if (instr_valid !== 4'hF) begin mismatched++; $display("FAIL midrun_valid got %h exp f", instr_valid); end
    reset = 1'b1; start = 1'b1; redirect_en = 4'hF; redirect_addr = {4{16'h5555}};
    tick;
    reset = 1'b0; start = 1'b0; redirect_en = 4'h0;
    compared++;
    if (instr !== 64'h0 || instr_valid !== 4'h0 || halted !== 4'h0 || all_halted !== 1'b0) begin
      mismatched++; $display("FAIL midrun_reset got %h/%h/%h/%b exp 0/0/0/0", instr, instr_valid, halted, all_halted);
    end
    compared++;
    if ({ram_address3, ram_address2, ram_address1, ram_address0} !== {16'd18, 16'd12, 16'd6, 16'd0}) begin
      mismatched++; $display("FAIL midrun_pcs got %h %h %h %h exp 0012 000c 0006 0000",
                             ram_address3, ram_address2, ram_address1, ram_address0);
    end
  endtask

  task automatic test_all_halted;
    do_reset;
    start_cores;
    repeat (24) tick;
    compared++;
    if (halted !== 4'b1110 || all_halted !== 1'b0) begin
      mismatched++; $display("FAIL all_halted_early got %h/%b exp e/0", halted, all_halted);
    end
    tick;
    compared++;
    if (halted !== 4'hF || all_halted !== 1'b1) begin
      mismatched++; $display("FAIL all_halted_final got %h/%b exp f/1", halted, all_halted);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    compared++;
    if (halted !== 4'h0 || all_halted !== 1'b0) begin
      mismatched++; $display("FAIL all_halted_reset got %h/%b exp 0/0", halted, all_halted);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_ready = 4'hF; redirect_en = 4'h0; redirect_addr = 64'h0;
    init_mem;
    test_reset;
    test_start_stream;
    test_stall;
    test_redirect;
    test_idle_redirect;
    test_halt;
    test_halt_stalled;
    test_wrap;
    test_reset_mid_run;
    test_all_halted;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
